// File: rtl/pcie_link_train_ctrl_if.sv
// ---------------------------------------------------------------------------
// pcie_link_train_ctrl_if
// Bundle between software/LTSSM side and the link-training supervisor.
//   enable        level request to run link training (0 forces IDLE)
//   retrain_req   single-cycle request to re-train an active link
//   clear_fail    single-cycle request to leave FAILED
//   link_up       link status from the LTSSM
//   init_state    to the LTSSM; 1 holds it in DETECT
//   link_active   1 while the link is trained
//   link_failed   1 while retries are exhausted
//   link_down_evt one-cycle pulse when an active link drops
//   retry_count   retries consumed in the current attempt
//   ctrl_state    supervisor state: IDLE=0 INIT=1 TRAIN=2 ACTIVE=3 BACKOFF=4 FAILED=5
// master drives the requests and link_up; slave is the supervisor.
// ---------------------------------------------------------------------------
interface pcie_link_train_ctrl_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  logic          enable;
  logic          retrain_req;
  logic          clear_fail;
  logic          link_up;
  logic          init_state;
  logic          link_active;
  logic          link_failed;
  logic          link_down_evt;
  logic [RW-1:0] retry_count;
  logic [2:0]    ctrl_state;

  modport master (
    output enable, retrain_req, clear_fail, link_up,
    input  init_state, link_active, link_failed, link_down_evt, retry_count, ctrl_state
  );

  modport slave (
    input  enable, retrain_req, clear_fail, link_up,
    output init_state, link_active, link_failed, link_down_evt, retry_count, ctrl_state
  );
endinterface

// File: rtl/pcie_link_train_ctrl.sv
// ---------------------------------------------------------------------------
// pcie_link_train_ctrl
// Link-training supervisor: pulses the LTSSM reset (init_state), waits for
// link_up against a timeout, backs off and retries up to MAX_RETRIES, then
// declares failure; tracks a trained link and re-trains on drop or request.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pcie_link_train_ctrl_if.slave (requests, link_up, status outputs)
// All outputs are decoded from registers; there is no input-to-output path.
// ---------------------------------------------------------------------------
module pcie_link_train_ctrl #(
  parameter int INIT_PULSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int BACKOFF_CYCLES    = 64,
  parameter int MAX_RETRIES       = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pcie_link_train_ctrl_if.slave bus
);

  localparam int RW      = $clog2(MAX_RETRIES + 1);
  localparam int MAX_A   = (INIT_PULSE_CYCLES > TIMEOUT_CYCLES) ? INIT_PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_A > BACKOFF_CYCLES) ? MAX_A : BACKOFF_CYCLES;
  localparam int TW      = $clog2(MAX_CNT + 1);

  localparam logic [TW-1:0] INIT_LAST    = TW'(INIT_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] BACKOFF_LAST = TW'(BACKOFF_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    TRAIN   = 3'd2,
    ACTIVE  = 3'd3,
    BACKOFF = 3'd4,
    FAILED  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          down_evt_q, down_evt_d;

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    retry_d    = retry_q;
    down_evt_d = 1'b0;

    if (!bus.enable) begin
      state_d = IDLE;
      retry_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = INIT;
          retry_d = '0;
        end
        INIT: begin
          timer_d = timer_q + 1'b1;
          if (timer_q == INIT_LAST) state_d = TRAIN;
        end
        TRAIN: begin
          timer_d = timer_q + 1'b1;
          // link_up wins over a timeout landing on the same edge.
          if (bus.link_up) begin
            state_d = ACTIVE;
            retry_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = FAILED;
            end else begin
              state_d = BACKOFF;
              retry_d = retry_q + 1'b1;
            end
          end
        end
        ACTIVE: begin
          // A drop outranks a simultaneous retrain request; the drop counts
          // as the first retry of the new attempt.
          if (!bus.link_up) begin
            state_d    = BACKOFF;
            retry_d    = RW'(1);
            down_evt_d = 1'b1;
          end else if (bus.retrain_req) begin
            state_d = INIT;
          end
        end
        BACKOFF: begin
          timer_d = timer_q + 1'b1;
          if (timer_q == BACKOFF_LAST) state_d = INIT;
        end
        FAILED: begin
          if (bus.clear_fail) begin
            state_d = IDLE;
            retry_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Each state entry starts its timer from zero.
    if (state_d != state_q) timer_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      down_evt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      down_evt_q <= down_evt_d;
    end
  end

  assign bus.ctrl_state    = state_q;
  assign bus.init_state    = !(state_q == TRAIN || state_q == ACTIVE);
  assign bus.link_active   = (state_q == ACTIVE);
  assign bus.link_failed   = (state_q == FAILED);
  assign bus.link_down_evt = down_evt_q;
  assign bus.retry_count   = retry_q;

endmodule

// File: tb/tb_pcie_link_train_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pcie_link_train_ctrl
// Directed scenarios followed by a randomized run. The reference model works
// on absolute edge numbers and deadlines rather than per-state counters.
// ---------------------------------------------------------------------------
module tb_pcie_link_train_ctrl;

  localparam int P  = 4;
  localparam int TO = 16;
  localparam int BO = 8;
  localparam int MR = 2;

  localparam int S_IDLE = 0, S_INIT = 1, S_TRAIN = 2, S_ACTIVE = 3, S_BACKOFF = 4, S_FAILED = 5;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  pcie_link_train_ctrl_if #(.MAX_RETRIES(MR)) bus ();

  pcie_link_train_ctrl #(
    .INIT_PULSE_CYCLES(P),
    .TIMEOUT_CYCLES   (TO),
    .BACKOFF_CYCLES   (BO),
    .MAX_RETRIES      (MR)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_st, m_retry, m_deadline, m_edge;
  bit m_evt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_retry = 0; m_deadline = 0; m_edge = 0; m_evt = 1'b0;
  endtask

  // One rising edge of the specified behaviour; inputs are stable around it.
  task automatic model_step();
    m_edge++;
    m_evt = 1'b0;
    if (!bus.enable) begin
      m_st = S_IDLE; m_retry = 0;
    end else begin
      case (m_st)
        S_IDLE: begin m_st = S_INIT; m_retry = 0; m_deadline = m_edge + P; end
        S_INIT: if (m_edge == m_deadline) begin m_st = S_TRAIN; m_deadline = m_edge + TO; end
        S_TRAIN: begin
          if (bus.link_up) begin
            m_st = S_ACTIVE; m_retry = 0;
          end else if (m_edge == m_deadline) begin
            if (m_retry >= MR) m_st = S_FAILED;
            else begin m_retry++; m_st = S_BACKOFF; m_deadline = m_edge + BO; end
          end
        end
        S_ACTIVE: begin
          if (!bus.link_up) begin
            m_evt = 1'b1; m_retry = 1; m_st = S_BACKOFF; m_deadline = m_edge + BO;
          end else if (bus.retrain_req) begin
            m_st = S_INIT; m_deadline = m_edge + P;
          end
        end
        S_BACKOFF: if (m_edge == m_deadline) begin m_st = S_INIT; m_deadline = m_edge + P; end
        S_FAILED: if (bus.clear_fail) begin m_st = S_IDLE; m_retry = 0; end
        default: m_st = S_IDLE;
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ctrl_state"},    32'(bus.ctrl_state),    32'(m_st));
    check({tag, ".init_state"},    32'(bus.init_state),    32'(!(m_st == S_TRAIN || m_st == S_ACTIVE)));
    check({tag, ".link_active"},   32'(bus.link_active),   32'(m_st == S_ACTIVE));
    check({tag, ".link_failed"},   32'(bus.link_failed),   32'(m_st == S_FAILED));
    check({tag, ".link_down_evt"}, 32'(bus.link_down_evt), 32'(m_evt));
    check({tag, ".retry_count"},   32'(bus.retry_count),   32'(m_retry));
  endtask

  // Advance one edge with the currently driven inputs and compare #1 later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Bounded wait until the model reaches a state; the DUT must be there too.
  task automatic run_until(input int st, input int budget, input string tag);
    int n = 0;
    while (m_st != st && n < budget) begin
      cycle(tag);
      n++;
    end
    check({tag, ".reached"}, 32'(bus.ctrl_state), 32'(st));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ctrl_state"},    32'(bus.ctrl_state),    32'd0);
    check({tag, ".init_state"},    32'(bus.init_state),    32'd1);
    check({tag, ".link_active"},   32'(bus.link_active),   32'd0);
    check({tag, ".link_failed"},   32'(bus.link_failed),   32'd0);
    check({tag, ".link_down_evt"}, 32'(bus.link_down_evt), 32'd0);
    check({tag, ".retry_count"},   32'(bus.retry_count),   32'd0);
  endtask

  initial begin
    bus.enable = 1'b0; bus.retrain_req = 1'b0; bus.clear_fail = 1'b0; bus.link_up = 1'b0;
    model_reset();

    // Reset
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    reset_n = 1'b1;
    cycle("idle_hold");

    // Happy path: enable at edge 0, link_up at edge 10
    bus.enable = 1'b1;
    cycle("happy_e0");
    check("happy_e0.init", 32'(bus.init_state), 32'd1);
    run(3, "happy_init");
    cycle("happy_e4");
    check("happy_e4.state", 32'(bus.ctrl_state), 32'(S_TRAIN));
    check("happy_e4.init", 32'(bus.init_state), 32'd0);
    run(5, "happy_train");
    bus.link_up = 1'b1;
    cycle("happy_e10");
    check("happy_e10.active", 32'(bus.link_active), 32'd1);
    run(3, "happy_active");

    // Link drop -> BACKOFF for 8 edges -> INIT; re-raise in TRAIN
    bus.link_up = 1'b0;
    cycle("drop");
    check("drop.evt", 32'(bus.link_down_evt), 32'd1);
    check("drop.retry", 32'(bus.retry_count), 32'd1);
    cycle("drop_next");
    check("drop_next.evt", 32'(bus.link_down_evt), 32'd0);
    run(6, "drop_backoff");
    cycle("drop_b8");
    check("drop_b8.state", 32'(bus.ctrl_state), 32'(S_INIT));
    run_until(S_TRAIN, 10, "drop_to_train");
    run(2, "drop_train");
    bus.link_up = 1'b1;
    cycle("relink");
    check("relink.retry", 32'(bus.retry_count), 32'd0);

    // retrain_req and drop on the same edge: drop wins
    bus.retrain_req = 1'b1; bus.link_up = 1'b0;
    cycle("rr_drop");
    check("rr_drop.state", 32'(bus.ctrl_state), 32'(S_BACKOFF));
    bus.retrain_req = 1'b0;

    // link_up exactly on the 16th TRAIN edge wins over timeout
    run_until(S_TRAIN, 20, "to_train2");
    run(TO - 1, "train_wait");
    bus.link_up = 1'b1;
    cycle("edge16");
    check("edge16.state", 32'(bus.ctrl_state), 32'(S_ACTIVE));

    // retrain_req alone: INIT, no retry charged
    bus.retrain_req = 1'b1;
    cycle("retrain");
    bus.retrain_req = 1'b0;
    check("retrain.state", 32'(bus.ctrl_state), 32'(S_INIT));

    // Exhausted retries -> FAILED; clear_fail returns to IDLE
    bus.link_up = 1'b0;
    bus.enable = 1'b0;
    cycle("disable");
    bus.enable = 1'b1;
    run_until(S_FAILED, 200, "exhaust");
    check("exhaust.retry", 32'(bus.retry_count), 32'(MR));
    check("exhaust.failed", 32'(bus.link_failed), 32'd1);
    run(3, "failed_hold");
    bus.clear_fail = 1'b1;
    cycle("clear_fail");
    bus.clear_fail = 1'b0;
    check("clear_fail.state", 32'(bus.ctrl_state), 32'(S_IDLE));
    check("clear_fail.retry", 32'(bus.retry_count), 32'd0);

    // enable=0 during BACKOFF -> IDLE next edge
    run_until(S_BACKOFF, 60, "to_backoff");
    run(2, "backoff");
    bus.enable = 1'b0;
    cycle("override");
    check("override.state", 32'(bus.ctrl_state), 32'(S_IDLE));
    check("override.retry", 32'(bus.retry_count), 32'd0);

    // Asynchronous reset in TRAIN
    bus.enable = 1'b1;
    run_until(S_TRAIN, 20, "to_train3");
    run(3, "train3");
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    @(posedge clk);
    #1 check_reset_values("reset_hold");
    bus.enable = 1'b0;
    reset_n = 1'b1;
    cycle("post_reset_idle");

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      bus.enable      = ($urandom_range(0, 99) >= 2);
      bus.retrain_req = ($urandom_range(0, 99) < 5);
      bus.clear_fail  = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 6) bus.link_up = ~bus.link_up;
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
